pong_match_ctrl: RTL and testbench

Match-level sequencer for the Pong game. It sits between the ball/paddle datapath and the score display. It tracks match state (idle, serve countdown, rally, point pause, game over) and gates ball motion and paddle control. It owns the two players' two-digit BCD scores and a winner flag. Point events from the ball block drive it, and the start of each video frame paces it.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_bcd_score.sv | 45 ++++
 rtl/pong_match_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: state codes, winner codes, BCD helpers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int BCD_W = 4;

  function automatic logic [BCD_W-1:0] bcd_digit(input int v);
    return BCD_W'(v % 10);
  endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD score with sync clear/increment; flags when the incremented value hits the target.
module pong_bcd_score
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [BCD_W-1:0] tgt_units_i,
  input  logic [BCD_W-1:0] tgt_tens_i,
  output logic [BCD_W-1:0] units_o,
  output logic [BCD_W-1:0] tens_o,
  output logic             hit_next_o
);

  logic [BCD_W-1:0] units_q, tens_q;
  logic [BCD_W-1:0] units_inc, tens_inc;

  always_comb begin
    if (units_q == BCD_W'(9)) begin
      units_inc = '0;
      tens_inc  = (tens_q == BCD_W'(9)) ? '0 : tens_q + BCD_W'(1);
    end else begin
      units_inc = units_q + BCD_W'(1);
      tens_inc  = tens_q;
    end
  end

  // Compared against the post-increment value so the caller can decide the win in the same cycle.
  assign hit_next_o = (units_inc == tgt_units_i) && (tens_inc == tgt_tens_i);

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      units_q <= '0;
      tens_q  <= '0;
    end else if (inc_i) begin
      units_q <= units_inc;
      tens_q  <= tens_inc;
    end
  end

  assign units_o = units_q;
  assign tens_o  = tens_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over flow, BCD scores and winner.
// Optional freeze state compiled in with `define PONG_PAUSE_EN.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       score1,
  input  logic       score2,
  output logic       ball_hold,
  output logic       ball_run,
  output logic       paddle_en,
  output logic       serve_dir,
  output logic [3:0] p1_units,
  output logic [3:0] p1_tens,
  output logic [3:0] p2_units,
  output logic [3:0] p2_tens,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int MAXF = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CW   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] POINT_LD = CW'(POINT_FRAMES - 1);
  localparam logic [BCD_W-1:0] WIN_U = bcd_digit(WIN_SCORE);
  localparam logic [BCD_W-1:0] WIN_T = bcd_digit(WIN_SCORE / 10);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    winner_q, winner_d;
  logic          dir_q, dir_d;
  logic          start_q, s1_q, s2_q;
  logic          clr, inc1, inc2, hit1, hit2;
  logic          start_rise, s1_rise, s2_rise;

  assign start_rise = start & ~start_q;
  assign s1_rise    = score1 & ~s1_q;
  assign s2_rise    = score2 & ~s2_q;

`ifdef PONG_PAUSE_EN
  state_e save_q, save_d;
  logic   pause_q, pause_rise;
  assign pause_rise = pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    dir_d    = dir_q;
    clr      = 1'b0;
    inc1     = 1'b0;
    inc2     = 1'b0;
`ifdef PONG_PAUSE_EN
    save_d   = save_q;
`endif
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          clr      = 1'b1;
          winner_d = WIN_NONE;
          dir_d    = 1'b0;
          cnt_d    = SERVE_LD;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE, ST_POINT: begin
`ifdef PONG_PAUSE_EN
        if (pause_rise) begin
          save_d  = state_q;
          state_d = ST_PAUSE;
        end else
`endif
        if (frame_tick) begin
          if (cnt_q == '0) begin
            if (state_q == ST_SERVE) begin
              state_d = ST_PLAY;
            end else begin
              cnt_d   = SERVE_LD;
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_PLAY: begin
        // Player 1 has priority on a simultaneous point; the loser of the point receives the serve.
        if (s1_rise) begin
          inc1  = 1'b1;
          dir_d = 1'b1;
          cnt_d = POINT_LD;
          if (hit1) begin
            winner_d = WIN_P1;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_POINT;
          end
        end else if (s2_rise) begin
          inc2  = 1'b1;
          dir_d = 1'b0;
          cnt_d = POINT_LD;
          if (hit2) begin
            winner_d = WIN_P2;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_POINT;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_rise) begin
          save_d  = ST_PLAY;
          state_d = ST_PAUSE;
        end
`endif
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSE: if (pause_rise) state_d = save_q;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      winner_q <= WIN_NONE;
      dir_q    <= 1'b0;
      start_q  <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      dir_q    <= dir_d;
      start_q  <= start;
      s1_q     <= score1;
      s2_q     <= score2;
    end
  end

`ifdef PONG_PAUSE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      save_q  <= ST_IDLE;
      pause_q <= 1'b0;
    end else begin
      save_q  <= save_d;
      pause_q <= pause;
    end
  end
`endif

  pong_bcd_score u_p1 (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(inc1),
    .tgt_units_i(WIN_U), .tgt_tens_i(WIN_T),
    .units_o(p1_units), .tens_o(p1_tens), .hit_next_o(hit1)
  );

  pong_bcd_score u_p2 (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(inc2),
    .tgt_units_i(WIN_U), .tgt_tens_i(WIN_T),
    .units_o(p2_units), .tens_o(p2_tens), .hit_next_o(hit2)
  );

  always_comb begin
    ball_hold = 1'b1;
    ball_run  = 1'b0;
    paddle_en = 1'b0;
    case (state_q)
      ST_SERVE, ST_POINT: paddle_en = 1'b1;
      ST_PLAY: begin
        ball_hold = 1'b0;
        ball_run  = 1'b1;
        paddle_en = 1'b1;
      end
      ST_PAUSE: ball_hold = 1'b0;
      default: ;
    endcase
  end

  assign serve_dir = dir_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: DUT a (WIN=3, SERVE=2, POINT=1) and DUT b (WIN=12).
module tb_pong_match_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT a
  logic a_reset, a_tick, a_start, a_pause, a_s1, a_s2;
  logic a_hold, a_run, a_pad, a_dir;
  logic [3:0] a_p1u, a_p1t, a_p2u, a_p2t;
  logic [1:0] a_win;
  logic [2:0] a_state;

  pong_match_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(1)) dut_a (
    .clk(clk), .reset(a_reset), .frame_tick(a_tick), .start(a_start), .pause(a_pause),
    .score1(a_s1), .score2(a_s2), .ball_hold(a_hold), .ball_run(a_run), .paddle_en(a_pad),
    .serve_dir(a_dir), .p1_units(a_p1u), .p1_tens(a_p1t), .p2_units(a_p2u), .p2_tens(a_p2t),
    .winner(a_win), .state(a_state)
  );

  // DUT b
  logic b_reset, b_tick, b_start, b_pause, b_s1, b_s2;
  logic b_hold, b_run, b_pad, b_dir;
  logic [3:0] b_p1u, b_p1t, b_p2u, b_p2t;
  logic [1:0] b_win;
  logic [2:0] b_state;

  pong_match_ctrl #(.WIN_SCORE(12), .SERVE_FRAMES(2), .POINT_FRAMES(1)) dut_b (
    .clk(clk), .reset(b_reset), .frame_tick(b_tick), .start(b_start), .pause(b_pause),
    .score1(b_s1), .score2(b_s2), .ball_hold(b_hold), .ball_run(b_run), .paddle_en(b_pad),
    .serve_dir(b_dir), .p1_units(b_p1u), .p1_tens(b_p1t), .p2_units(b_p2u), .p2_tens(b_p2t),
    .winner(b_win), .state(b_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; return #1 after the last so outputs are settled.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_frame();
    a_tick = 1'b1; cyc(1); a_tick = 1'b0;
  endtask

  task automatic a_serve_to_play();
    a_frame(); a_frame();
  endtask

  task automatic b_frame();
    b_tick = 1'b1; cyc(1); b_tick = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_tick = 0; a_start = 0; a_pause = 0; a_s1 = 0; a_s2 = 0;
    b_reset = 1'b1; b_tick = 0; b_start = 0; b_pause = 0; b_s1 = 0; b_s2 = 0;
    cyc(2);
    a_reset = 1'b0; b_reset = 1'b0;

    check("rst_state", 8'(a_state), 8'd0);
    check("rst_hold_run_pad", {5'b0, a_hold, a_run, a_pad}, 8'b100);
    check("rst_scores", {a_p1t, a_p1u}, 8'h00);
    check("rst_winner", 8'(a_win), 8'd0);

    // Start rise -> SERVE
    a_start = 1'b1; cyc(1); a_start = 1'b0;
    check("start_serve", 8'(a_state), 8'd1);
    check("serve_outputs", {5'b0, a_hold, a_run, a_pad}, 8'b101);
    a_frame();
    check("serve_after_1tick", 8'(a_state), 8'd1);
    a_frame();
    check("play_after_2ticks", 8'(a_state), 8'd2);
    check("play_outputs", {5'b0, a_hold, a_run, a_pad}, 8'b011);

    // Player 2 scores
    a_s2 = 1'b1; cyc(1); a_s2 = 1'b0;
    check("p2_point_units", 8'(a_p2u), 8'd1);
    check("p2_point_dir", 8'(a_dir), 8'd0);
    check("p2_point_state", 8'(a_state), 8'd3);
    check("point_outputs", {5'b0, a_hold, a_run, a_pad}, 8'b101);
    a_frame();
    check("point_to_serve", 8'(a_state), 8'd1);
    a_serve_to_play();

    // Simultaneous points: player 1 wins the tie
    a_s1 = 1'b1; a_s2 = 1'b1; cyc(1); a_s1 = 1'b0; a_s2 = 1'b0;
    check("tie_p1", 8'(a_p1u), 8'd1);
    check("tie_p2", 8'(a_p2u), 8'd1);
    check("tie_dir", 8'(a_dir), 8'd1);
    a_frame(); a_serve_to_play();
    a_s1 = 1'b1; cyc(1); a_s1 = 1'b0;
    check("p1_second", 8'(a_p1u), 8'd2);
    a_frame(); a_serve_to_play();
    check("midplay_state", 8'(a_state), 8'd2);

    // Reset mid-PLAY at 2-1
    a_reset = 1'b1; cyc(1); a_reset = 1'b0;
    check("midrst_state", 8'(a_state), 8'd0);
    check("midrst_scores", {a_p1u, a_p2u}, 8'h00);
    check("midrst_hold_pad", {6'b0, a_hold, a_pad}, 8'b10);
    check("midrst_dir", 8'(a_dir), 8'd0);

    // New match; pause behaviour during serve after one tick
    a_start = 1'b1; cyc(1); a_start = 1'b0;
    a_frame();
    a_pause = 1'b1; cyc(1); a_pause = 1'b0;
`ifdef PONG_PAUSE_EN
    check("pause_enter", 8'(a_state), 8'd5);
    check("pause_outputs", {5'b0, a_hold, a_run, a_pad}, 8'b000);
    repeat (5) a_frame();
    check("pause_frozen", 8'(a_state), 8'd5);
    a_s1 = 1'b1; cyc(1); a_s1 = 1'b0;
    check("pause_score_ignored", 8'(a_p1u), 8'd0);
    a_pause = 1'b1; cyc(1); a_pause = 1'b0;
    check("unpause_serve", 8'(a_state), 8'd1);
`else
    check("pause_ignored", 8'(a_state), 8'd1);
`endif
    a_frame();
    check("resume_play_1tick", 8'(a_state), 8'd2);

    // Player 1 to 3 points
    a_s1 = 1'b1; cyc(1); a_s1 = 1'b0;
    a_frame(); a_serve_to_play();
    a_s1 = 1'b1; cyc(1); a_s1 = 1'b0;
    check("p1_two_point", 8'(a_state), 8'd3);
    a_frame(); a_serve_to_play();
    a_s1 = 1'b1; cyc(1); a_s1 = 1'b0;
    check("win_p1_units", 8'(a_p1u), 8'd3);
    check("win_flag", 8'(a_win), 8'd1);
    check("win_state", 8'(a_state), 8'd4);
    check("over_outputs", {5'b0, a_hold, a_run, a_pad}, 8'b100);
    cyc(1);
    a_s1 = 1'b1; cyc(1); a_s1 = 1'b0;
    check("over_score_ignored", 8'(a_p1u), 8'd3);
    check("over_state_kept", 8'(a_state), 8'd4);

    // Restart from OVER
    a_start = 1'b1; cyc(1); a_start = 1'b0;
    check("restart_state", 8'(a_state), 8'd1);
    check("restart_scores", {a_p1u, a_p2u}, 8'h00);
    check("restart_winner", 8'(a_win), 8'd0);
    a_pause = 1'b1; cyc(1); a_pause = 1'b0;
`ifdef PONG_PAUSE_EN
    check("pause_in_serve", 8'(a_state), 8'd5);
`else
    check("pause_in_serve_ignored", 8'(a_state), 8'd1);
`endif
    a_reset = 1'b1; cyc(1); a_reset = 1'b0;
    check("reset_from_pause", 8'(a_state), 8'd0);

    // DUT b: ten points to player 1 exercise the BCD carry
    b_start = 1'b1; cyc(1); b_start = 1'b0;
    b_frame(); b_frame();
    check("b_play", 8'(b_state), 8'd2);
    for (int i = 0; i < 10; i++) begin
      b_s1 = 1'b1; cyc(1); b_s1 = 1'b0;
      if (i < 9) begin b_frame(); b_frame(); b_frame(); end
    end
    check("b_ten", {b_p1t, b_p1u}, 8'h10);
    check("b_ten_no_win", 8'(b_win), 8'd0);
    check("b_ten_state", 8'(b_state), 8'd3);
    for (int i = 0; i < 2; i++) begin
      b_frame(); b_frame(); b_frame();
      b_s1 = 1'b1; cyc(1); b_s1 = 1'b0;
    end
    check("b_twelve", {b_p1t, b_p1u}, 8'h12);
    check("b_win", 8'(b_win), 8'd1);
    check("b_over", 8'(b_state), 8'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
